// File: rtl/object_pkg.sv
// Shared definitions for the object box tracker.
//   COORD_W        coordinate width
//   IMG_*_DEF      default active frame size
//   trk_state_e    tracker state encoding driven onto trk_state
//   mid2 / absdiff helpers for the centre-step jump gate
package object_pkg;
  localparam int COORD_W  = 11;
  localparam int NUM_AXES = 4;  // 0 up, 1 down, 2 left, 3 right

  localparam logic [COORD_W-1:0] IMG_HDISP_DEF = 11'd960;
  localparam logic [COORD_W-1:0] IMG_VDISP_DEF = 11'd540;

  typedef enum logic [1:0] {
    TRK_IDLE    = 2'd0,
    TRK_ACQUIRE = 2'd1,
    TRK_TRACK   = 2'd2,
    TRK_COAST   = 2'd3
  } trk_state_e;

  function automatic logic [COORD_W-1:0] mid2(input logic [COORD_W-1:0] a,
                                              input logic [COORD_W-1:0] b);
    logic [COORD_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[COORD_W:1];
  endfunction

  function automatic logic [COORD_W-1:0] absdiff(input logic [COORD_W-1:0] a,
                                                 input logic [COORD_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction
endpackage

// File: rtl/box_axis_iir.sv
// One box coordinate: holds the stabilised value and applies load / filter / hold.
//   clk, rst_n   clock, async active-low reset
//   load_i       replace the coordinate with meas_i
//   filt_i       move by (meas_i - box) >>> ALPHA_SHIFT, clamped to 0..LIMIT
//   meas_i       captured detector coordinate
//   box_o        stabilised coordinate
module box_axis_iir
  import object_pkg::*;
#(
  parameter int                 ALPHA_SHIFT = 2,
  parameter logic [COORD_W-1:0] LIMIT       = IMG_HDISP_DEF - 11'd1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               filt_i,
  input  logic [COORD_W-1:0] meas_i,
  output logic [COORD_W-1:0] box_o
);
  logic [COORD_W-1:0]        box_q, box_d, filt_val;
  logic signed [COORD_W:0]   diff, step;
  logic signed [COORD_W+1:0] sum;

  assign diff = $signed({1'b0, meas_i}) - $signed({1'b0, box_q});
  // Arithmetic shift floors toward -inf: approach from above is exact,
  // approach from below may stall up to 2^ALPHA_SHIFT-1 short, never oscillates.
  assign step = diff >>> ALPHA_SHIFT;
  assign sum  = $signed({2'b00, box_q}) + $signed({step[COORD_W], step});

  always_comb begin
    filt_val = sum[COORD_W-1:0];
    if (sum[COORD_W+1])                            filt_val = '0;
    else if (sum > $signed({2'b00, LIMIT}))        filt_val = LIMIT;
  end

  always_comb begin
    box_d = box_q;
    if (load_i)      box_d = meas_i;
    else if (filt_i) box_d = filt_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) box_q <= '0;
    else        box_q <= box_d;
  end

  assign box_o = box_q;
endmodule

// File: rtl/object_box_tracker.sv
// Per-frame temporal stabiliser for the detector bounding box.
// Samples rect_*/flag on the rising edge of per_frame_vsync, validates the box,
// runs an IDLE/ACQUIRE/TRACK/COAST tracker and smooths the box with a shift IIR.
// Outputs update two cycles after the vsync edge strobe and hold for the frame.
//   clk, rst_n           clock, async active-low reset
//   per_frame_vsync      frame sync (high = frame active)
//   rect_up/down/left/right, flag   detector box and object flag
//   box_up/down/left/right          stabilised box
//   box_valid            overlay should draw the box (TRACK or COAST)
//   trk_state            0 IDLE, 1 ACQUIRE, 2 TRACK, 3 COAST
// Optional: define OBJECT_BOX_CENTRE_EN to add centre_x / centre_y outputs,
// registered one cycle after the box.
module object_box_tracker
  import object_pkg::*;
#(
  parameter logic [COORD_W-1:0] IMG_HDISP   = IMG_HDISP_DEF,
  parameter logic [COORD_W-1:0] IMG_VDISP   = IMG_VDISP_DEF,
  parameter int                 ACQ_FRAMES  = 3,
  parameter int                 LOST_FRAMES = 8,
  parameter int                 ALPHA_SHIFT = 2,
  parameter logic [COORD_W-1:0] JUMP_MAX    = 11'd128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               per_frame_vsync,
  input  logic [COORD_W-1:0] rect_up,
  input  logic [COORD_W-1:0] rect_down,
  input  logic [COORD_W-1:0] rect_left,
  input  logic [COORD_W-1:0] rect_right,
  input  logic               flag,
  output logic [COORD_W-1:0] box_up,
  output logic [COORD_W-1:0] box_down,
  output logic [COORD_W-1:0] box_left,
  output logic [COORD_W-1:0] box_right,
  output logic               box_valid,
  output logic [1:0]         trk_state
`ifdef OBJECT_BOX_CENTRE_EN
  ,
  output logic [COORD_W-1:0] centre_x,
  output logic [COORD_W-1:0] centre_y
`endif
);
  localparam int         STAGES = 2;
  localparam logic [3:0] ACQ_N  = 4'(ACQ_FRAMES);
  localparam logic [3:0] LOST_N = 4'(LOST_FRAMES);

  // vld_pipe_q[1]: capture done, update due; vld_pipe_q[2]: box just updated
  logic              vsync_q, strobe;
  logic [STAGES:1]   vld_pipe_q;
  logic              hit_d, hit_q;
  logic [NUM_AXES-1:0][COORD_W-1:0] meas_q, box;
  trk_state_e        state_q, state_d;
  logic [3:0]        hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic              jump, load, filt;

  assign strobe = per_frame_vsync & ~vsync_q;

  assign hit_d = flag & (rect_up <= rect_down) & (rect_left <= rect_right) &
                 (rect_down < IMG_VDISP) & (rect_right < IMG_HDISP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q    <= 1'b0;
      vld_pipe_q <= '0;
      hit_q      <= 1'b0;
      meas_q     <= '0;
    end else begin
      vsync_q    <= per_frame_vsync;
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], strobe};
      if (strobe) begin
        hit_q  <= hit_d;
        meas_q <= {rect_right, rect_left, rect_down, rect_up};
      end
    end
  end

  // Large centre step means a new object position: reload rather than smear.
  assign jump = (absdiff(mid2(meas_q[2], meas_q[3]), mid2(box[2], box[3])) > JUMP_MAX) |
                (absdiff(mid2(meas_q[0], meas_q[1]), mid2(box[0], box[1])) > JUMP_MAX);

  always_comb begin
    state_d    = state_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    load       = 1'b0;
    filt       = 1'b0;
    if (vld_pipe_q[1]) begin
      case (state_q)
        TRK_IDLE: if (hit_q) begin
          if (ACQ_N == 4'd1) begin
            state_d = TRK_TRACK; load = 1'b1; hit_cnt_d = '0;
          end else begin
            state_d = TRK_ACQUIRE; hit_cnt_d = 4'd1;
          end
        end
        TRK_ACQUIRE: if (hit_q) begin
          if (hit_cnt_q + 4'd1 >= ACQ_N) begin
            state_d = TRK_TRACK; load = 1'b1; hit_cnt_d = '0;
          end else begin
            hit_cnt_d = hit_cnt_q + 4'd1;
          end
        end else begin
          state_d = TRK_IDLE; hit_cnt_d = '0;
        end
        TRK_TRACK: if (hit_q) begin
          load = jump; filt = ~jump;
        end else if (LOST_N == 4'd1) begin
          state_d = TRK_IDLE; miss_cnt_d = '0;
        end else begin
          state_d = TRK_COAST; miss_cnt_d = 4'd1;
        end
        TRK_COAST: if (hit_q) begin
          state_d = TRK_TRACK; miss_cnt_d = '0; load = jump; filt = ~jump;
        end else if (miss_cnt_q + 4'd1 >= LOST_N) begin
          state_d = TRK_IDLE; miss_cnt_d = '0;
        end else begin
          miss_cnt_d = miss_cnt_q + 4'd1;
        end
        default: state_d = TRK_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TRK_IDLE;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  for (genvar g = 0; g < NUM_AXES; g++) begin : g_axis
    box_axis_iir #(
      .ALPHA_SHIFT(ALPHA_SHIFT),
      .LIMIT      ((g < 2) ? (IMG_VDISP - 11'd1) : (IMG_HDISP - 11'd1))
    ) u_iir (
      .clk   (clk),
      .rst_n (rst_n),
      .load_i(load),
      .filt_i(filt),
      .meas_i(meas_q[g]),
      .box_o (box[g])
    );
  end

  assign box_up    = box[0];
  assign box_down  = box[1];
  assign box_left  = box[2];
  assign box_right = box[3];
  assign box_valid = (state_q == TRK_TRACK) || (state_q == TRK_COAST);
  assign trk_state = state_q;

`ifdef OBJECT_BOX_CENTRE_EN
  logic [COORD_W-1:0] centre_x_q, centre_y_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      centre_x_q <= '0;
      centre_y_q <= '0;
    end else if (vld_pipe_q[2]) begin
      centre_x_q <= mid2(box[2], box[3]);
      centre_y_q <= mid2(box[0], box[1]);
    end
  end
  assign centre_x = centre_x_q;
  assign centre_y = centre_y_q;
`endif
endmodule

// File: tb/tb_object_box_tracker.sv
module tb_object_box_tracker;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        per_frame_vsync;
  logic [10:0] rect_up, rect_down, rect_left, rect_right;
  logic        flag;
  logic [10:0] box_up, box_down, box_left, box_right;
  logic        box_valid;
  logic [1:0]  trk_state;
`ifdef OBJECT_BOX_CENTRE_EN
  logic [10:0] centre_x, centre_y;
`endif

  object_box_tracker dut (
    .clk(clk), .rst_n(rst_n), .per_frame_vsync(per_frame_vsync),
    .rect_up(rect_up), .rect_down(rect_down), .rect_left(rect_left),
    .rect_right(rect_right), .flag(flag),
    .box_up(box_up), .box_down(box_down), .box_left(box_left),
    .box_right(box_right), .box_valid(box_valid), .trk_state(trk_state)
`ifdef OBJECT_BOX_CENTRE_EN
    , .centre_x(centre_x), .centre_y(centre_y)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] u, d, l, r;
    logic        f;
    logic [1:0]  st;
    logic        v;
    logic [10:0] bu, bd, bl, br;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int u, d, l, r, f, st, v, bu, bd, bl, br);
    vec_t x;
    x.u = 11'(u); x.d = 11'(d); x.l = 11'(l); x.r = 11'(r); x.f = 1'(f);
    x.st = 2'(st); x.v = 1'(v);
    x.bu = 11'(bu); x.bd = 11'(bd); x.bl = 11'(bl); x.br = 11'(br);
    vecs.push_back(x);
  endtask

  // Drive a box with the vsync rising edge, scramble inputs after capture,
  // then idle with vsync low so the outputs are seen holding mid-frame.
  task automatic start_frame(input logic [10:0] u, d, l, r, input logic f);
    @(negedge clk);
    rect_up = u; rect_down = d; rect_left = l; rect_right = r; flag = f;
    per_frame_vsync = 1'b1;
  endtask

  task automatic scramble();
    rect_up = 11'd10; rect_down = 11'd20; rect_left = 11'd30; rect_right = 11'd40;
    flag = 1'b1;
  endtask

  task automatic end_frame();
    @(negedge clk);
    per_frame_vsync = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame(input logic [10:0] u, d, l, r, input logic f);
    start_frame(u, d, l, r, f);
    @(posedge clk); #1 scramble();
    @(posedge clk); #1;
    end_frame();
  endtask

  initial begin
    rst_n = 1'b0; per_frame_vsync = 1'b0; flag = 1'b0;
    rect_up = '0; rect_down = '0; rect_left = '0; rect_right = '0;

    // acquisition
    add(100,200,300,400,1, 1,0, 0,0,0,0);
    add(100,200,300,400,1, 1,0, 0,0,0,0);
    add(100,200,300,400,1, 2,1, 100,200,300,400);
    // IIR convergence on left 300 -> 340
    add(100,200,340,400,1, 2,1, 100,200,310,400);
    add(100,200,340,400,1, 2,1, 100,200,317,400);
    add(100,200,340,400,1, 2,1, 100,200,322,400);
    add(100,200,340,400,1, 2,1, 100,200,326,400);
    add(100,200,340,400,1, 2,1, 100,200,329,400);
    add(100,200,340,400,1, 2,1, 100,200,331,400);
    add(100,200,340,400,1, 2,1, 100,200,333,400);
    add(100,200,340,400,1, 2,1, 100,200,334,400);
    add(100,200,340,400,1, 2,1, 100,200,335,400);
    add(100,200,340,400,1, 2,1, 100,200,336,400);
    add(100,200,340,400,1, 2,1, 100,200,337,400);
    add(100,200,340,400,1, 2,1, 100,200,337,400);
    // 3 misses then a hit returns to TRACK
    for (int i = 0; i < 3; i++) add(100,200,340,400,0, 3,1, 100,200,337,400);
    add(100,200,340,400,1, 2,1, 100,200,337,400);
    // 8 misses: COAST x7 then IDLE with box held
    for (int i = 0; i < 7; i++) add(100,200,340,400,0, 3,1, 100,200,337,400);
    add(100,200,340,400,0, 0,0, 100,200,337,400);
    // invalid boxes in ACQUIRE
    add(100,200,300,400,1, 1,0, 100,200,337,400);
    add(250,200,300,400,1, 0,0, 100,200,337,400);
    add(100,200,300,400,1, 1,0, 100,200,337,400);
    add(100,200,300,960,1, 0,0, 100,200,337,400);
    add(100,200,300,400,1, 1,0, 100,200,337,400);
    add(100,540,300,400,1, 0,0, 100,200,337,400);
    // edge-valid boxes still acquire
    add(100,200,300,959,1, 1,0, 100,200,337,400);
    add(200,200,300,300,1, 1,0, 100,200,337,400);
    add(100,200,300,400,1, 2,1, 100,200,300,400);
    // jump gate
    add(100,200,500,600,1, 2,1, 100,200,500,600);
    add(100,200,628,728,1, 2,1, 100,200,532,632);
    add(300,400,532,632,1, 2,1, 300,400,532,632);
    add(290,400,532,632,1, 2,1, 297,400,532,632);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("reset state", trk_state, 0);
    check("reset valid", box_valid, 0);
    check("reset box", {box_up, box_down, box_left, box_right}, 0);

    foreach (vecs[i]) begin
      frame(vecs[i].u, vecs[i].d, vecs[i].l, vecs[i].r, vecs[i].f);
      check($sformatf("v%0d state", i), trk_state, vecs[i].st);
      check($sformatf("v%0d valid", i), box_valid, vecs[i].v);
      check($sformatf("v%0d up", i),    box_up,    vecs[i].bu);
      check($sformatf("v%0d down", i),  box_down,  vecs[i].bd);
      check($sformatf("v%0d left", i),  box_left,  vecs[i].bl);
      check($sformatf("v%0d right", i), box_right, vecs[i].br);
    end

    // reset mid-TRACK with an update in flight
    start_frame(11'd100, 11'd200, 11'd500, 11'd600, 1'b1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("midrst state", trk_state, 0);
    check("midrst valid", box_valid, 0);
    check("midrst left", box_left, 0);
    check("midrst up", box_up, 0);
    per_frame_vsync = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("postrst state", trk_state, 0);
    check("postrst right", box_right, 0);

    // pipeline timing: no change at strobe+1, update at strobe+2
    start_frame(11'd100, 11'd200, 11'd300, 11'd400, 1'b1);
    @(posedge clk); #1 scramble();
    check("s1 state", trk_state, 0);
    @(posedge clk); #1;
    check("s2 state", trk_state, 1);
    end_frame();
    frame(11'd100, 11'd200, 11'd300, 11'd401, 1'b1);
    check("acq2 state", trk_state, 1);
    start_frame(11'd100, 11'd200, 11'd300, 11'd401, 1'b1);
    @(posedge clk); #1 scramble();
    check("acq3 s1 valid", box_valid, 0);
    @(posedge clk); #1;
    check("acq3 state", trk_state, 2);
    check("acq3 valid", box_valid, 1);
    check("acq3 right", box_right, 401);
    check("acq3 left", box_left, 300);
`ifdef OBJECT_BOX_CENTRE_EN
    check("centre_x s2", centre_x, 0);
    @(posedge clk); #1;
    check("centre_x s3", centre_x, 350);
    check("centre_y s3", centre_y, 150);
`endif
    end_frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
